// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: behavioural 1RW+1R SRAM with reset clear sweep and write-first port 1 forwarding.
// Latency: 1 cycle read on both ports; the clear sweep holds init_busy for RAM_DEPTH cycles after reset release.
// Backpressure: none while running; requests during the sweep are ignored. Optional per-lane parity: define SRAM_PARITY_EN.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                                clk0,
  input  logic                                rst0,
  output logic                                init_busy,
  input  logic                                csb0,
  input  logic                                web0,
  input  logic [DATA_WIDTH/WMASK_WIDTH-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]               addr0,
  input  logic [DATA_WIDTH-1:0]               din0,
  output logic [DATA_WIDTH-1:0]               dout0,
  input  logic                                csb1,
  input  logic [ADDR_WIDTH-1:0]               addr1,
  output logic [DATA_WIDTH-1:0]               dout1
`ifdef SRAM_PARITY_EN
  ,
  output logic                                perr0,
  output logic                                perr1,
  input  logic                                pinv0
`endif
);

  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  // The sweep's first write (address 0) happens on the release edge itself,
  // so the counter only has to walk the remaining RAM_DEPTH-1 addresses.
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(RAM_DEPTH - 2);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
  endgenerate

  logic                  r_state;
  logic                  r_rel;      // reset-release synchroniser, set on first edge after rst0 falls
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

  logic                  w_run;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_fwd;
  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic [DATA_WIDTH-1:0] w_merge_dat;

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] r_par [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] w_din_par;
  logic [NUM_WMASKS-1:0] w_init_par;
  logic [NUM_WMASKS-1:0] w_merge_par;

  function automatic logic [NUM_WMASKS-1:0] f_lane_par(input logic [DATA_WIDTH-1:0] d);
    f_lane_par = '0;
    for (int l = 0; l < NUM_WMASKS; l++) begin
      f_lane_par[l] = ^d[l*WMASK_WIDTH +: WMASK_WIDTH];
    end
  endfunction
`endif

  assign init_busy    = (r_state == ST_INIT);
  assign w_run        = (r_state == ST_RUN);
  assign w_wr0        = w_run & ~csb0 & ~web0;
  assign w_rd0        = w_run & ~csb0 & web0;
  assign w_rd1        = w_run & ~csb1;
  assign w_fwd        = w_wr0 && (addr0 == addr1);
  assign w_sweep_addr = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, r_rel};

  // Port 1 read word: stored word with same-cycle port 0 write lanes forwarded in
  always_comb begin
    w_merge_dat = r_mem[addr1];
`ifdef SRAM_PARITY_EN
    w_din_par   = f_lane_par(din0);
    w_init_par  = f_lane_par(INIT_VALUE);
    w_merge_par = r_par[addr1];
`endif
    for (int l = 0; l < NUM_WMASKS; l++) begin
      if (w_fwd && wmask0[l]) begin
        w_merge_dat[l*WMASK_WIDTH +: WMASK_WIDTH] = din0[l*WMASK_WIDTH +: WMASK_WIDTH];
`ifdef SRAM_PARITY_EN
        w_merge_par[l] = w_din_par[l];
`endif
      end
    end
  end

  // FSM and sweep counter: async entry into INIT, synchronised release into the sweep
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_rel   <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_rel <= 1'b1;
      if (r_rel) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == LAST_CNT) begin
          r_state <= ST_RUN;
        end
      end
    end
  end

  // Storage array: clear sweep during INIT (address 0 is rewritten while reset is held), masked port 0 writes in RUN
  always_ff @(posedge clk0) begin
    if (!w_run) begin
      r_mem[w_sweep_addr] <= INIT_VALUE;
`ifdef SRAM_PARITY_EN
      r_par[w_sweep_addr] <= w_init_par;
`endif
    end else if (w_wr0) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (wmask0[l]) begin
          r_mem[addr0][l*WMASK_WIDTH +: WMASK_WIDTH] <= din0[l*WMASK_WIDTH +: WMASK_WIDTH];
`ifdef SRAM_PARITY_EN
          r_par[addr0][l] <= w_din_par[l] ^ pinv0;
`endif
        end
      end
    end
  end

  // Read data registers: update only on reads, otherwise hold; parity flags clear when not reading
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      dout0 <= '0;
      dout1 <= '0;
`ifdef SRAM_PARITY_EN
      perr0 <= 1'b0;
      perr1 <= 1'b0;
`endif
    end else begin
      if (w_rd0) begin
        dout0 <= r_mem[addr0];
      end
      if (w_rd1) begin
        dout1 <= w_merge_dat;
      end
`ifdef SRAM_PARITY_EN
      perr0 <= w_rd0 && (|(f_lane_par(r_mem[addr0]) ^ r_par[addr0]));
      perr1 <= w_rd1 && (|(f_lane_par(w_merge_dat) ^ w_merge_par));
`endif
    end
  end

endmodule
